// File: rtl/cu_ram_ctrl_pkg.sv
// Shared types for the control-unit RAM access sequencer.
// Op and state encodings plus default widths.
package cu_ram_ctrl_pkg;

  localparam int OPERAND_SIZE = 8;
  localparam int RAM_ADDR_W   = 8;

  typedef enum logic [1:0] {
    OP_ILLEGAL = 2'b00,
    OP_READ    = 2'b01,
    OP_WRITE   = 2'b10,
    OP_CLEAR   = 2'b11
  } cu_ram_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_CLR  = 3'd3,
    S_RESP = 3'd4
  } cu_ram_state_e;

endpackage

// File: rtl/cu_ram_ctrl.sv
// Sequences read/write/clear requests onto the cu_ram pins.
// RAM pins are registered so they are stable at the RAM's negedge.
module cu_ram_ctrl
  import cu_ram_ctrl_pkg::*;
#(
  parameter int DATA_W = OPERAND_SIZE,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_read,
  output logic              ram_write,
  output logic              ram_enable,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [ADDR_W:0] LAST =
    {1'b0, {ADDR_W{1'b1}}};

  cu_ram_state_e   state;
  logic [ADDR_W:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      ram_enable  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            case (req_op)
              OP_READ: begin
                ram_enable  <= 1'b1;
                ram_read    <= 1'b1;
                ram_address <= req_addr;
                state       <= S_RD;
              end
              OP_WRITE: begin
                ram_enable  <= 1'b1;
                ram_write   <= 1'b1;
                ram_address <= req_addr;
                ram_data_in <= req_wdata;
                state       <= S_WR;
              end
              OP_CLEAR: begin
                cnt         <= '0;
                ram_enable  <= 1'b1;
                ram_write   <= 1'b1;
                ram_address <= '0;
                ram_data_in <= '0;
                state       <= S_CLR;
              end
              default: begin
                rsp_err <= 1'b1;
                state   <= S_RESP;
              end
            endcase
          end
        end
        S_RD: begin
          rsp_rdata   <= ram_data_out;
          rsp_valid   <= 1'b1;
          ram_enable  <= 1'b0;
          ram_read    <= 1'b0;
          ram_address <= '0;
          state       <= S_RESP;
        end
        S_WR: begin
          rsp_rdata   <= '0;
          rsp_valid   <= 1'b1;
          ram_enable  <= 1'b0;
          ram_write   <= 1'b0;
          ram_address <= '0;
          ram_data_in <= '0;
          state       <= S_RESP;
        end
        S_CLR: begin
          if (cnt == LAST) begin
            rsp_rdata   <= '0;
            rsp_valid   <= 1'b1;
            ram_enable  <= 1'b0;
            ram_write   <= 1'b0;
            ram_address <= '0;
            state       <= S_RESP;
          end else begin
            cnt         <= cnt + 1'b1;
            ram_address <= ADDR_W'(cnt + 1'b1);
          end
        end
        S_RESP: begin
          // Illegal ops arrive here without valid; raise it one cycle on.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cu_ram_ctrl.sv
// Directed bench for cu_ram_ctrl with a behavioural negedge RAM.
// Vector table plus hand sequences for hold, reset and throughput.
module tb_cu_ram_ctrl;
  import cu_ram_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic          ram_read;
  logic          ram_write;
  logic          ram_enable;
  logic [DW-1:0] ram_data_out;

  always #5 clk = ~clk;

  cu_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .ram_address (ram_address),
    .ram_data_in (ram_data_in),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .ram_enable  (ram_enable),
    .ram_data_out(ram_data_out)
  );

  // RAM model: acts on negedge, bus shows junk when not reading.
  logic [DW-1:0] mem [256] = '{default: 8'h00};
  logic [DW-1:0] ram_dout = 8'hEE;
  assign ram_data_out = ram_dout;

  always @(negedge clk) begin
    ram_dout <= 8'hEE;
    if (ram_enable && ram_read)
      ram_dout <= mem[ram_address];
    if (ram_enable && ram_write)
      mem[ram_address] <= ram_data_in;
  end

  int cyc = 0;
  int rw_bad = 0;
  int en_bad = 0;
  int en_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_read && ram_write) rw_bad++;
    if (ram_enable != (ram_read | ram_write)) en_bad++;
    if (ram_enable) en_cnt++;
  end

  int n_chk = 0;
  int n_fail = 0;
  int en0 = 0;
  int acc_cyc = 0;
  int lat = 0;
  logic [31:0] got_rdata;
  logic [31:0] got_err;
  logic [31:0] got_en;
  bit rr_hold = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [1:0] op,
                       input logic [7:0] a,
                       input logic [7:0] d);
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      chk("req_ready wait", 32'(req_ready), 1);
      return;
    end
    en0 = en_cnt;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 8'($urandom);
    req_wdata = 8'($urandom);
    acc_cyc   = cyc;
  endtask

  task automatic wait_rsp(input int budget);
    lat = 0;
    while (!rsp_valid && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_valid wait", 32'(rsp_valid), 1);
    got_rdata = 32'(rsp_rdata);
    got_err   = 32'(rsp_err);
    got_en    = 32'(en_cnt != en0);
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = rr_hold;
  endtask

  typedef struct {
    string      nm;
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_lat;
    logic       exp_en;
  } vec_t;

  vec_t v [11];
  int prev_acc;

  initial begin
    v[0]  = '{"wr10",  OP_WRITE,   8'h10, 8'hA5, 8'h00, 0, 1,   1};
    v[1]  = '{"rd10",  OP_READ,    8'h10, 8'h00, 8'hA5, 0, 1,   1};
    v[2]  = '{"wrFF",  OP_WRITE,   8'hFF, 8'h3C, 8'h00, 0, 1,   1};
    v[3]  = '{"wr80",  OP_WRITE,   8'h80, 8'h11, 8'h00, 0, 1,   1};
    v[4]  = '{"rdFF",  OP_READ,    8'hFF, 8'h00, 8'h3C, 0, 1,   1};
    v[5]  = '{"rd80",  OP_READ,    8'h80, 8'h00, 8'h11, 0, 1,   1};
    v[6]  = '{"illeg", OP_ILLEGAL, 8'h33, 8'h99, 8'h00, 1, 1,   0};
    v[7]  = '{"clear", OP_CLEAR,   8'h44, 8'h77, 8'h00, 0, 256, 1};
    v[8]  = '{"rdFFc", OP_READ,    8'hFF, 8'h00, 8'h00, 0, 1,   1};
    v[9]  = '{"rd80c", OP_READ,    8'h80, 8'h00, 8'h00, 0, 1,   1};
    v[10] = '{"rd10c", OP_READ,    8'h10, 8'h00, 8'h00, 0, 1,   1};

    #1;
    chk("rst req_ready",  32'(req_ready), 0);
    chk("rst rsp_valid",  32'(rsp_valid), 0);
    chk("rst ram_enable", 32'(ram_enable), 0);
    chk("rst ram_addr",   32'(ram_address), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post-rst req_ready", 32'(req_ready), 1);

    for (int i = 0; i < 11; i++) begin
      issue(v[i].op, v[i].addr, v[i].wdata);
      wait_rsp(300);
      chk({v[i].nm, " lat"},   32'(lat), 32'(v[i].exp_lat));
      chk({v[i].nm, " rdata"}, got_rdata, 32'(v[i].exp_rdata));
      chk({v[i].nm, " err"},   got_err, 32'(v[i].exp_err));
      chk({v[i].nm, " ram_en"}, got_en, 32'(v[i].exp_en));
      take();
      chk({v[i].nm, " rsp drop"}, 32'(rsp_valid), 0);
      chk({v[i].nm, " ready"},    32'(req_ready), 1);
    end

    // Response held while the consumer stalls.
    issue(OP_WRITE, 8'h20, 8'h5A); wait_rsp(5); take();
    issue(OP_WRITE, 8'h30, 8'hC3); wait_rsp(5); take();
    issue(OP_READ, 8'h20, 8'h00);
    wait_rsp(5);
    chk("hold first rdata", got_rdata, 32'h5A);
    req_valid = 1'b1;
    req_op    = OP_READ;
    req_addr  = 8'h30;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold valid", 32'(rsp_valid), 1);
      chk("hold rdata", 32'(rsp_rdata), 32'h5A);
      chk("hold req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("hold released", 32'(rsp_valid), 0);
    chk("hold ready back", 32'(req_ready), 1);
    en0 = en_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pending accepted", 32'(req_ready), 0);
    wait_rsp(5);
    chk("pending lat", 32'(lat), 1);
    chk("pending rdata", got_rdata, 32'hC3);
    take();

    // Reset in the middle of a clear sweep.
    issue(OP_WRITE, 8'd50,  8'h44); wait_rsp(5); take();
    issue(OP_WRITE, 8'd150, 8'h66); wait_rsp(5); take();
    issue(OP_WRITE, 8'd200, 8'h77); wait_rsp(5); take();
    issue(OP_CLEAR, 8'h00, 8'h00);
    repeat (99) @(posedge clk);
    #2;
    chk("sweep active", 32'(ram_write), 1);
    reset = 1'b0;
    #1;
    chk("arst ram_enable", 32'(ram_enable), 0);
    chk("arst ram_write",  32'(ram_write), 0);
    chk("arst ram_addr",   32'(ram_address), 0);
    chk("arst rsp_valid",  32'(rsp_valid), 0);
    chk("arst req_ready",  32'(req_ready), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rel req_ready", 32'(req_ready), 1);
    chk("rel no rsp", 32'(rsp_valid), 0);
    issue(OP_READ, 8'd200, 8'h00); wait_rsp(5);
    chk("rd200 kept", got_rdata, 32'h77); take();
    issue(OP_READ, 8'd150, 8'h00); wait_rsp(5);
    chk("rd150 kept", got_rdata, 32'h66); take();
    issue(OP_READ, 8'd50, 8'h00); wait_rsp(5);
    chk("rd50 cleared", got_rdata, 32'h00); take();

    // Back-to-back writes with the consumer always ready.
    rr_hold = 1'b1;
    rsp_ready = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      issue(OP_WRITE, 8'(i), 8'(i * 17 + 1));
      if (i > 0) chk("b2b interval", 32'(acc_cyc - prev_acc), 3);
      prev_acc = acc_cyc;
      wait_rsp(5);
      take();
    end
    rr_hold = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue(OP_READ, 8'(i), 8'h00);
      wait_rsp(5);
      chk("b2b readback", got_rdata, 32'(8'(i * 17 + 1)));
      take();
    end

    chk("rd/wr overlap cycles", 32'(rw_bad), 0);
    chk("enable consistency", 32'(en_bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
